// File: rtl/bbox_scan_ctrl.sv
// Raster-scan read sequencer: walks the image RAM in row-major order and emits a
// valid/ready pixel stream tagged with x/y/last, absorbing RAM latency and backpressure.
module bbox_scan_ctrl #(
  parameter int unsigned IMG_W  = 768,
  parameter int unsigned IMG_H  = 512,
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned PIX_W  = 24,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned XW     = 10,
  parameter int unsigned YW     = 10
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_rden,
  input  logic [PIX_W-1:0]  ram_q,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic [XW-1:0]     pix_x,
  output logic [YW-1:0]     pix_y,
  output logic              pix_last
);

  localparam int unsigned D  = RD_LAT + 1;
  localparam int unsigned PW = $clog2(D);
  localparam int unsigned CW = $clog2(D + 1);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StDrain = 2'd2;
  localparam logic [1:0] StDone  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [XW-1:0]     ix_q;
  logic [YW-1:0]     iy_q;
  logic [CW-1:0]     outst_q;
  logic              issue_last;
  logic              push;
  logic              pop;

  // Tag pipeline that travels alongside each read until ram_q is valid.
  logic              sr_vld_q  [RD_LAT];
  logic [XW-1:0]     sr_x_q    [RD_LAT];
  logic [YW-1:0]     sr_y_q    [RD_LAT];
  logic              sr_last_q [RD_LAT];

  logic [PIX_W-1:0]  mem_data [D];
  logic [XW-1:0]     mem_x    [D];
  logic [YW-1:0]     mem_y    [D];
  logic              mem_last [D];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(D - 1)) ? '0 : p + PW'(1);
  endfunction

  assign issue_last = (ix_q == XW'(IMG_W - 1)) && (iy_q == YW'(IMG_H - 1));
  assign pix_valid  = (count_q != '0);
  assign pop        = pix_valid && pix_ready;
  assign push       = sr_vld_q[RD_LAT-1];

  // A same-cycle pop frees a slot, so one read per cycle is sustained with pix_ready high.
  assign ram_rden = (state_q == StIssue) && ((outst_q < CW'(D)) || pop);
  assign ram_addr = addr_q;
  assign busy     = (state_q == StIssue) || (state_q == StDrain);
  assign done     = (state_q == StDone);

  // Outputs are gated so an empty FIFO presents zeros rather than stale entries.
  assign pix_data = pix_valid ? mem_data[rd_ptr_q] : '0;
  assign pix_x    = pix_valid ? mem_x[rd_ptr_q]    : '0;
  assign pix_y    = pix_valid ? mem_y[rd_ptr_q]    : '0;
  assign pix_last = pix_valid && mem_last[rd_ptr_q];

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (start) state_d = StIssue;
      StIssue: if (ram_rden && issue_last) state_d = StDrain;
      StDrain: if (pop && pix_last) state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (abort) state_d = StIdle;
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset || abort) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      ix_q     <= '0;
      iy_q     <= '0;
      outst_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q <= state_d;
      if (ram_rden) begin
        addr_q <= addr_q + ADDR_W'(1);
        if (ix_q == XW'(IMG_W - 1)) begin
          ix_q <= '0;
          iy_q <= iy_q + YW'(1);
        end else begin
          ix_q <= ix_q + XW'(1);
        end
      end else if ((state_q == StIdle) || (state_q == StDone)) begin
        addr_q <= '0;
        ix_q   <= '0;
        iy_q   <= '0;
      end
      case ({ram_rden, pop})
        2'b10:   outst_q <= outst_q + CW'(1);
        2'b01:   outst_q <= outst_q - CW'(1);
        default: outst_q <= outst_q;
      endcase
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  for (genvar g = 0; g < RD_LAT; g++) begin : g_stage
    if (g == 0) begin : g_head
      always_ff @(posedge CLOCK_50) begin
        if (reset || abort) sr_vld_q[g] <= 1'b0;
        else                sr_vld_q[g] <= ram_rden;
      end
      always_ff @(posedge CLOCK_50) begin
        sr_x_q[g]    <= ix_q;
        sr_y_q[g]    <= iy_q;
        sr_last_q[g] <= issue_last;
      end
    end else begin : g_tail
      always_ff @(posedge CLOCK_50) begin
        if (reset || abort) sr_vld_q[g] <= 1'b0;
        else                sr_vld_q[g] <= sr_vld_q[g-1];
      end
      always_ff @(posedge CLOCK_50) begin
        sr_x_q[g]    <= sr_x_q[g-1];
        sr_y_q[g]    <= sr_y_q[g-1];
        sr_last_q[g] <= sr_last_q[g-1];
      end
    end
  end

  // Payload storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge CLOCK_50) begin
    if (push) begin
      mem_data[wr_ptr_q] <= ram_q;
      mem_x[wr_ptr_q]    <= sr_x_q[RD_LAT-1];
      mem_y[wr_ptr_q]    <= sr_y_q[RD_LAT-1];
      mem_last[wr_ptr_q] <= sr_last_q[RD_LAT-1];
    end
  end

endmodule
